// File: rtl/dram_block_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dram_pkg
// Brief   : Shared types and sizing constants for dram_block_responder.
// Rev     : 1.0  initial release
// ============================================================================

`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

package dram_pkg;
  localparam int DRAM_ADDR_W       = `DRAM_ADDRESS_SIZE;
  localparam int DRAM_WORD_W       = `DRAM_WORD_SIZE;
  localparam int DRAM_BLOCK_WORDS  = `DRAM_BLOCK_SIZE;
  localparam int DRAM_DEPTH_WORDS  = 4096;
  localparam int BLOCK_OFFSET_BITS = $clog2(DRAM_BLOCK_WORDS);
  localparam int INDEX_BITS        = $clog2(DRAM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } dram_state_t;

  typedef logic [DRAM_WORD_W-1:0] word_t;
  typedef word_t [DRAM_BLOCK_WORDS-1:0] block_t;
endpackage

`default_nettype wire

// File: rtl/dram_block_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dram_rr_arbiter
// Brief   : Two-requester round-robin arbiter holding the last-served port.
// Rev     : 1.0  initial release
// ============================================================================

module dram_rr_arbiter (
  input  logic clock,
  input  logic reset,
  input  logic reqP1,
  input  logic reqP2,
  input  logic grantEn,
  output logic grantP1,
  output logic grantP2
);

  logic r_lastServedP2;

  // Port 1 wins unless port 2 is also asking and port 1 was served last.
  always_comb begin
    grantP1 = reqP1 & (~reqP2 | r_lastServedP2);
    grantP2 = reqP2 & ~grantP1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lastServedP2 <= 1'b1;
    end else if (grantEn && (grantP1 || grantP2)) begin
      r_lastServedP2 <= grantP2;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_block_responder.sv
`default_nettype none
// ============================================================================
// Module  : dram_block_responder
// Brief   : Two-port block DRAM responder with round-robin arbitration and
//           fixed latency. Define DRAM_STATS_EN for transaction counters.
// Rev     : 1.0  initial release
// ============================================================================

module dram_block_responder
  import dram_pkg::*;
#(
  parameter int ADDR_W      = DRAM_ADDR_W,
  parameter int WORD_W      = DRAM_WORD_W,
  parameter int BLOCK_WORDS = DRAM_BLOCK_WORDS,
  parameter int DEPTH_WORDS = DRAM_DEPTH_WORDS,
  parameter int LATENCY     = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               dram_port1_request,
  input  logic [ADDR_W-1:0]                  dram_port1_address,
  input  logic                               dram_port1_we,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0] dram_port1_read_data,
  output logic                               dram_port1_acknowledge,
  input  logic                               dram_port2_request,
  input  logic [ADDR_W-1:0]                  dram_port2_address,
  input  logic                               dram_port2_we,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0] dram_port2_write_data,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0] dram_port2_read_data,
  output logic                               dram_port2_acknowledge,
  output logic                               dram_busy
`ifdef DRAM_STATS_EN
  ,
  output logic [31:0]                        stat_p1_reads,
  output logic [31:0]                        stat_p2_reads,
  output logic [31:0]                        stat_p2_writes
`endif
);

  localparam int c_idxBits = $clog2(DEPTH_WORDS);
  localparam int c_cntBits = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_idxBits-1:0] c_alignMask = ~c_idxBits'(BLOCK_WORDS - 1);

  dram_state_t                        r_state;
  logic [c_cntBits-1:0]               r_counter;
  logic                               r_grantP2;
  logic                               r_we;
  logic [c_idxBits-1:0]               r_blockBase;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] r_writeData;
  logic [WORD_W-1:0]                  r_mem [DEPTH_WORDS];

  logic                               w_idle;
  logic                               w_grantP1;
  logic                               w_grantP2;
  logic [ADDR_W-1:0]                  w_addr;
  logic [c_idxBits-1:0]               w_base;
  logic                               w_commitWrite;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] w_readBlock;
  logic                               w_unusedBits;

  assign w_idle = (r_state == IDLE);

  dram_rr_arbiter u_arbiter (
    .clock   (clock),
    .reset   (reset),
    .reqP1   (dram_port1_request),
    .reqP2   (dram_port2_request),
    .grantEn (w_idle),
    .grantP1 (w_grantP1),
    .grantP2 (w_grantP2)
  );

  // High address bits fall away so out-of-range addresses alias silently.
  assign w_addr        = w_grantP2 ? dram_port2_address : dram_port1_address;
  assign w_base        = w_addr[c_idxBits+1:2] & c_alignMask;
  assign w_commitWrite = (r_state == ACCESS) && (r_counter == '0) && r_we;
  assign w_unusedBits  = ^{dram_port1_we, w_addr[ADDR_W-1:c_idxBits+2], w_addr[1:0]};

  always_comb begin
    w_readBlock = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      w_readBlock[i] = r_mem[r_blockBase | c_idxBits'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (w_commitWrite) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        r_mem[r_blockBase | c_idxBits'(i)] <= r_writeData[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state                <= IDLE;
      r_counter              <= '0;
      r_grantP2              <= 1'b0;
      r_we                   <= 1'b0;
      r_blockBase            <= '0;
      r_writeData            <= '0;
      dram_port1_read_data   <= '0;
      dram_port2_read_data   <= '0;
      dram_port1_acknowledge <= 1'b0;
      dram_port2_acknowledge <= 1'b0;
      dram_busy              <= 1'b0;
    end else begin
      dram_port1_acknowledge <= 1'b0;
      dram_port2_acknowledge <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantP1 || w_grantP2) begin
            r_grantP2   <= w_grantP2;
            r_we        <= w_grantP2 & dram_port2_we;
            r_blockBase <= w_base;
            r_writeData <= dram_port2_write_data;
            r_counter   <= c_cntBits'(LATENCY - 1);
            r_state     <= ACCESS;
            dram_busy   <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_counter == '0) begin
            if (!r_we) begin
              if (r_grantP2) dram_port2_read_data <= w_readBlock;
              else           dram_port1_read_data <= w_readBlock;
            end
            if (r_grantP2) dram_port2_acknowledge <= 1'b1;
            else           dram_port1_acknowledge <= 1'b1;
            r_state <= ACK;
          end else begin
            r_counter <= r_counter - c_cntBits'(1);
          end
        end
        ACK: begin
          r_state   <= IDLE;
          dram_busy <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          dram_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAM_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_p1_reads  <= '0;
      stat_p2_reads  <= '0;
      stat_p2_writes <= '0;
    end else if (r_state == ACK) begin
      if (!r_grantP2) begin
        if (stat_p1_reads != '1) stat_p1_reads <= stat_p1_reads + 32'd1;
      end else if (r_we) begin
        if (stat_p2_writes != '1) stat_p2_writes <= stat_p2_writes + 32'd1;
      end else begin
        if (stat_p2_reads != '1) stat_p2_reads <= stat_p2_reads + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_block_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dram_block_responder
// Brief   : Self-checking bench with a word-array reference model.
// Rev     : 1.0  initial release
// ============================================================================

module tb_dram_block_responder;
  import dram_pkg::*;

  localparam int LAT     = 8;
  localparam int DEPTH   = 4096;
  localparam int BW      = DRAM_BLOCK_WORDS;
  localparam int TIMEOUT = 60;

  logic        clock = 1'b0;
  logic        reset;
  logic        p1Req, p1We, p1Ack;
  logic [31:0] p1Addr;
  block_t      p1Rd;
  logic        p2Req, p2We, p2Ack;
  logic [31:0] p2Addr;
  block_t      p2Wd, p2Rd;
  logic        busy;
`ifdef DRAM_STATS_EN
  logic [31:0] statP1Reads, statP2Reads, statP2Writes;
`endif

  dram_block_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .dram_port1_request     (p1Req),
    .dram_port1_address     (p1Addr),
    .dram_port1_we          (p1We),
    .dram_port1_read_data   (p1Rd),
    .dram_port1_acknowledge (p1Ack),
    .dram_port2_request     (p2Req),
    .dram_port2_address     (p2Addr),
    .dram_port2_we          (p2We),
    .dram_port2_write_data  (p2Wd),
    .dram_port2_read_data   (p2Rd),
    .dram_port2_acknowledge (p2Ack),
    .dram_busy              (busy)
`ifdef DRAM_STATS_EN
    ,
    .stat_p1_reads          (statP1Reads),
    .stat_p2_reads          (statP2Reads),
    .stat_p2_writes         (statP2Writes)
`endif
  );

  always #5 clock = ~clock;

  int     checkCount = 0;
  int     failCount  = 0;
  word_t  modelMem [int];
  block_t expRd1, expRd2;
  int     lastServed;
  int     cntP1Reads, cntP2Reads, cntP2Writes;

  task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int blockBase(input logic [31:0] addr);
    int wordIdx;
    wordIdx = int'(addr >> 2) % DEPTH;
    return wordIdx - (wordIdx % BW);
  endfunction

  function automatic block_t modelRead(input logic [31:0] addr);
    block_t blk;
    int     b;
    b = blockBase(addr);
    for (int i = 0; i < BW; i++) blk[i] = modelMem.exists(b + i) ? modelMem[b + i] : '0;
    return blk;
  endfunction

  function automatic block_t randBlock();
    block_t blk;
    for (int i = 0; i < BW; i++) blk[i] = $urandom;
    return blk;
  endfunction

  task automatic applyTxn(input int port, input logic [31:0] addr, input logic isWrite, input block_t data);
    int b;
    b = blockBase(addr);
    if (isWrite) begin
      for (int i = 0; i < BW; i++) modelMem[b + i] = data[i];
      cntP2Writes++;
    end else if (port == 1) begin
      expRd1 = modelRead(addr);
      cntP1Reads++;
    end else begin
      expRd2 = modelRead(addr);
      cntP2Reads++;
    end
  endtask

  task automatic doTxn(input int port, input logic [31:0] addr, input logic we,
                       input block_t data, input bit dropEarly);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    if (port == 1) begin
      p1Req = 1'b1; p1Addr = addr; p1We = we;
    end else begin
      p2Req = 1'b1; p2Addr = addr; p2We = we; p2Wd = data;
    end
    while (!got && cyc < TIMEOUT) begin
      tick();
      cyc++;
      if (dropEarly && cyc == 1) begin
        p1Req = 1'b0;
        p2Req = 1'b0;
      end
      if (p1Ack || p2Ack) got = 1'b1;
      else checkValue("busy_access", busy, 1'b1);
    end
    checkValue("ack_seen", got, 1'b1);
    checkValue("ack_latency", cyc, LAT + 1);
    checkValue("ack_port", {p1Ack, p2Ack}, (port == 1) ? 2'b10 : 2'b01);
    checkValue("busy_ack", busy, 1'b1);
    lastServed = port;
    applyTxn(port, addr, (port == 2) && we, data);
    checkValue("rd1", p1Rd, expRd1);
    checkValue("rd2", p2Rd, expRd2);
    tick();
    p1Req = 1'b0;
    p2Req = 1'b0;
    checkValue("ack_pulse", {p1Ack, p2Ack}, 2'b00);
    checkValue("busy_idle", busy, 1'b0);
  endtask

  task automatic doBoth(input logic [31:0] addr1, input logic [31:0] addr2,
                        input logic we2, input block_t data2);
    int cyc, a1, a2, first;
    cyc   = 0;
    a1    = 0;
    a2    = 0;
    first = (lastServed == 2) ? 1 : 2;
    p1Req = 1'b1; p1Addr = addr1; p1We = 1'($urandom_range(0, 1));
    p2Req = 1'b1; p2Addr = addr2; p2We = we2; p2Wd = data2;
    while ((a1 == 0 || a2 == 0) && cyc < 2 * TIMEOUT) begin
      tick();
      cyc++;
      if (p1Ack && a1 == 0) a1 = cyc;
      if (p2Ack && a2 == 0) a2 = cyc;
      if (a1 != 0 && cyc == a1 + 1) p1Req = 1'b0;
      if (a2 != 0 && cyc == a2 + 1) p2Req = 1'b0;
    end
    checkValue("both_first_ack", (first == 1) ? a1 : a2, LAT + 1);
    checkValue("both_second_ack", (first == 1) ? a2 : a1, 2 * LAT + 3);
    if (first == 1) begin
      applyTxn(1, addr1, 1'b0, '0);
      applyTxn(2, addr2, we2, data2);
      lastServed = 2;
    end else begin
      applyTxn(2, addr2, we2, data2);
      applyTxn(1, addr1, 1'b0, '0);
      lastServed = 1;
    end
    checkValue("both_rd1", p1Rd, expRd1);
    checkValue("both_rd2", p2Rd, expRd2);
    tick();
    p1Req = 1'b0;
    p2Req = 1'b0;
    checkValue("both_busy_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] addrA, addrB;
    block_t      blkA;

    reset = 1'b0;
    p1Req = 1'b0; p1We = 1'b0; p1Addr = '0;
    p2Req = 1'b0; p2We = 1'b0; p2Addr = '0; p2Wd = '0;
    expRd1 = '0; expRd2 = '0;
    lastServed = 2;
    cntP1Reads = 0; cntP2Reads = 0; cntP2Writes = 0;

    repeat (3) tick();
    checkValue("reset_busy", busy, 1'b0);
    checkValue("reset_ack", {p1Ack, p2Ack}, 2'b00);
    checkValue("reset_rd1", p1Rd, expRd1);
    checkValue("reset_rd2", p2Rd, expRd2);
    reset = 1'b1;
    tick();

    // Directed: preload, read-back, write-then-read, aliasing
    blkA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    doTxn(2, 32'h100, 1'b1, blkA, 1'b0);
    doTxn(1, 32'h100, 1'b1, '0, 1'b0);
    checkValue("tp_p1_block", p1Rd, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    doTxn(2, 32'h200, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    doTxn(2, 32'h20C, 1'b0, '0, 1'b0);
    checkValue("tp_wr_rd", p2Rd, {32'd4, 32'd3, 32'd2, 32'd1});
    doTxn(1, 32'h4100, 1'b0, '0, 1'b1);
    checkValue("tp_alias", p1Rd, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Reset during the fourth ACCESS cycle of a port 2 write
    p2Req = 1'b1; p2Addr = 32'h200; p2We = 1'b1; p2Wd = {4{32'hDEADBEEF}};
    repeat (4) tick();
    #1 reset = 1'b0;
    #1;
    expRd1 = '0; expRd2 = '0;
    lastServed = 2;
    cntP1Reads = 0; cntP2Reads = 0; cntP2Writes = 0;
    checkValue("abort_busy", busy, 1'b0);
    checkValue("abort_ack", {p1Ack, p2Ack}, 2'b00);
    checkValue("abort_rd1", p1Rd, expRd1);
    checkValue("abort_rd2", p2Rd, expRd2);
    p2Req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (LAT + 2) begin
      tick();
      checkValue("abort_no_ack", {p1Ack, p2Ack}, 2'b00);
    end

    // Contention: alternation from a fresh reset, block at 0x200 intact
    repeat (4) doBoth(32'h100, 32'h200, 1'b0, '0);

    // Randomised traffic over a small pool of blocks
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'($urandom_range(0, DEPTH / BW - 1) * BW * 4);
      doTxn(2, pool[i], 1'b1, randBlock(), 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      addrA = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3) << 14)
              + 32'($urandom_range(0, BW * 4 - 1));
      addrB = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3) << 14);
      if ($urandom_range(0, 3) == 0)
        doBoth(addrA, addrB, 1'($urandom_range(0, 1)), randBlock());
      else if ($urandom_range(0, 1) == 0)
        doTxn(1, addrA, 1'($urandom_range(0, 1)), '0, 1'($urandom_range(0, 1)));
      else
        doTxn(2, addrA, 1'($urandom_range(0, 1)), randBlock(), 1'($urandom_range(0, 1)));
    end

`ifdef DRAM_STATS_EN
    checkValue("stat_p1_reads", statP1Reads, cntP1Reads);
    checkValue("stat_p2_reads", statP2Reads, cntP2Reads);
    checkValue("stat_p2_writes", statP2Writes, cntP2Writes);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_block_responder.md
Name: dram_block_responder

Overview:
- Memory-side responder for the two cache block ports: port 1 serves instruction-cache block reads, port 2 serves data-cache block reads and write-backs.
- Holds the backing word array, arbitrates between the two ports and models a fixed access latency.
- Returns whole blocks with a one-cycle acknowledge pulse.
- Sits below the icache/dcache controllers, in place of the bare DRAM model.

Parameters:
- ADDR_W, `DRAM_ADDRESS_SIZE (32): byte address width.
- WORD_W, `DRAM_WORD_SIZE (32): word width.
- BLOCK_WORDS, `DRAM_BLOCK_SIZE (4): words per block, power of two.
- DEPTH_WORDS, 4096: array depth in words, power of two.
- LATENCY, 8: cycles from grant to acknowledge, must be ≥1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dram_port1_request  in  1  port 1 block request, level held until acknowledge.
- dram_port1_address  in  ADDR_W  port 1 byte address.
- dram_port1_we  in  1  write enable; must be 0, and is ignored.
- dram_port1_read_data  out  WORD_W x BLOCK_WORDS  port 1 read block.
- dram_port1_acknowledge  out  1  one-cycle completion pulse.
- dram_port2_request  in  1  port 2 block request.
- dram_port2_address  in  ADDR_W  port 2 byte address.
- dram_port2_we  in  1  1 = write block, 0 = read block.
- dram_port2_write_data  in  WORD_W x BLOCK_WORDS  write-back block.
- dram_port2_read_data  out  WORD_W x BLOCK_WORDS  port 2 read block.
- dram_port2_acknowledge  out  1  one-cycle completion pulse.
- dram_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset = 0, async):
  - state IDLE; acknowledges 0; dram_busy 0.
  - Both read_data registers all-zero; counter 0; last_served = port 2.
  - Array contents are not cleared.
- Addressing:
  - Word index = address >> 2.
  - Block base = word index with the low log2(BLOCK_WORDS) bits cleared.
  - Index is taken modulo DEPTH_WORDS, so out-of-range addresses wrap silently.
  - Word i of a block maps to base+i; element [0] is the lowest address.
- FSM states: IDLE, ACCESS, ACK.
  - IDLE: if any request is high, grant a port, latch its address, we and write data, load counter = LATENCY-1, go to ACCESS.
  - ACCESS: decrement counter each cycle. When counter = 0:
    - Read: copy the block into the granted port's read_data register.
    - Write: store write_data into the array.
    - Go to ACK.
  - ACK: the granted port's acknowledge = 1 for exactly this cycle; read_data is valid. Then go to IDLE.
- Latency: acknowledge is asserted LATENCY+1 cycles after the IDLE cycle in which the request was first seen high. Minimum back-to-back period is LATENCY+2 cycles.
- Arbitration:
  - Single request: that port wins.
  - Both requests high in IDLE: round-robin; the port not in last_served wins. last_served updates at grant.
  - First contention after reset goes to port 1.
- Handshake:
  - Requester holds request, address and data stable until acknowledge.
  - Requester must drive request low in the cycle after acknowledge.
  - A request dropped before acknowledge is still completed (latched), and acknowledge still pulses.
  - read_data holds its value until that port's next read completes. Writes do not alter read_data.
- Port 2 write then read of the same block: the read returns the new data; accesses are strictly serialised.
- Reset asserted mid-access:
  - Transaction aborted; no acknowledge.
  - A pending write is not performed unless it was already committed in the counter = 0 cycle.
- dram_port1_we = 1 is ignored; port 1 always reads.

Optional Feature:
- DRAM_STATS_EN defined adds three outputs, each 32-bit and saturating at all-ones:
  - stat_p1_reads
  - stat_p2_reads
  - stat_p2_writes
- Each increments in the ACK cycle of the matching transaction, and resets to 0.
- When not defined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dram_pkg holds:
  - typedef dram_state_t {IDLE, ACCESS, ACK}
  - typedef word_t [WORD_W-1:0]
  - typedef block_t (word_t array of BLOCK_WORDS)
  - localparams BLOCK_OFFSET_BITS, INDEX_BITS
- One sub-module: dram_rr_arbiter, a two-requester round-robin arbiter with the last_served register.

Test Plan:
- Preload word[64..67] = 0xA0..0xA3; port 1 requests address 0x100 (LATENCY = 8) -> dram_port1_acknowledge pulses at cycle 9 with read_data {0xA0, 0xA1, 0xA2, 0xA3}; dram_busy high for cycles 1-9.
- Port 2 writes {1, 2, 3, 4} to 0x200, then reads 0x20C -> read returns {1, 2, 3, 4}; the second acknowledge comes 10 cycles after the first.
- Both ports request in the same cycle after reset -> port 1 is acknowledged first and port 2 10 cycles later; repeat both -> port 1 wins again only after port 2 has been served (alternation holds over 4 rounds).
- Address 0x4000 + 0x100 with DEPTH_WORDS = 4096 -> aliases to 0x100 and returns the same block.
- Reset pulsed at ACCESS cycle 4 of a port 2 write -> no acknowledge, target array words unchanged, all outputs 0.
- DRAM_STATS_EN defined: 3 port 1 reads, 2 port 2 writes, 1 port 2 read -> counters read 3 / 1 / 2.
